ahblite_busmatrix_outputstage_dtcm: RTL and testbench
=====================================================

Name: ahblite_busmatrix_outputstage_dtcm

Overview:
Output-stage arbiter that shares the single DTCM AHB-lite slave port between two bus-matrix input stages: M0 (CPU) and M1 (accelerator). It sits between the per-master decoders and the DTCM slave. Each cycle it selects one master's address phase and routes that master's control to the slave. It tracks which master owns the data phase so write data is steered correctly. It returns a per-master ACTIVE flag to the decoders.

Parameters:
RR_MODE, 1, 1 = round-robin between M0/M1; 0 = fixed priority, M0 wins.

Ports:
HCLK  in  1  clock
HRESETn  in  1  async active-low reset
HSEL_M0, HSEL_M1  in  1  decoder select for DTCM
HADDR_M0, HADDR_M1  in  32  address
HTRANS_M0, HTRANS_M1  in  2  transfer type
HWRITE_M0, HWRITE_M1  in  1  write
HSIZE_M0, HSIZE_M1  in  3  size
HBURST_M0, HBURST_M1  in  3  burst
HPROT_M0, HPROT_M1  in  4  protection
HMASTLOCK_M0, HMASTLOCK_M1  in  1  locked sequence
HWDATA_M0, HWDATA_M1  in  32  write data
HREADYOUT_S  in  1  slave ready
ACTIVE_M0, ACTIVE_M1  out  1  master owns the current address phase
HSEL_O  out  1  slave select
HADDR_O  out  32  muxed address
HTRANS_O  out  2  muxed transfer type
HWRITE_O  out  1  muxed write
HSIZE_O  out  3  muxed size
HBURST_O  out  3  muxed burst
HPROT_O  out  4  muxed protection
HMASTLOCK_O  out  1  muxed lock
HWDATA_O  out  32  write data of the data-phase owner
HREADY_O  out  1  HREADY to slave, equal to HREADYOUT_S

Behaviour:
- Reset: HRESETn is asynchronous, active-low; clock is HCLK.
- Registered state and reset values:
  - addr_sel_q = NONE
  - data_sel = NONE
  - hold_q = 0
  - last_grant = M1, so M0 wins the first contention.
- Request: req_x = HSEL_Mx & HTRANS_Mx[1] (NONSEQ or SEQ).
- Sticky condition: the owner in addr_sel_q keeps the grant while:
  - HSEL_Mx=1, and
  - HTRANS_Mx is SEQ or BUSY, or HMASTLOCK_Mx=1.
  The other master cannot break a burst or a locked sequence.
- Combinational arbitration, arb, in priority order:
  1. Sticky owner.
  2. Both requesting: M(~last_grant) if RR_MODE=1, else M0.
  3. Single requester.
  4. Otherwise NONE.
- Stall hold:
  - hold_q <= ~HREADY_O every cycle.
  - addr_sel = hold_q ? addr_sel_q : arb.
  - addr_sel_q <= addr_sel every cycle.
  - The address phase never changes while the slave is stalled.
- Address outputs:
  - addr_sel=NONE: HSEL_O=0, HTRANS_O=IDLE; all other control and address = 0.
  - Otherwise: all address/control come from the selected master, and HSEL_O = HSEL_Mx.
- ACTIVE_Mx = (addr_sel==Mx); combinational, 0 during reset.
- Grant bookkeeping: when HREADY_O=1 and addr_sel!=NONE with HTRANS_O[1]=1:
  - data_sel <= addr_sel
  - last_grant <= addr_sel
- Idle cycle: when HREADY_O=1 and no valid transfer, data_sel <= NONE.
- HWDATA_O = data_sel==M0 ? HWDATA_M0 : data_sel==M1 ? HWDATA_M1 : 0. It lags the address by one accepted phase.
- Latency: zero-cycle arbitration. A request is presented to the slave in the same cycle it appears, if the slave is ready and there is no contention.
- Simultaneous events:
  - Grant switches only on a cycle where hold_q=0.
  - A losing master sees ACTIVE=0 and its input stage holds the request.
  - The loser is granted on the next free address slot.
- Reset mid-transfer: all state returns to reset values immediately. Outputs go IDLE with HSEL_O=0 while HRESETn=0.
- BUSY from the owner: sticky; BUSY is forwarded without a data phase (HTRANS_O[1]=0).

Test Plan:
- Reset; M0 NONSEQ single write to 0x2000_0010 with HREADYOUT_S=1 -> same cycle: ACTIVE_M0=1, HADDR_O=0x20000010, HTRANS_O=2. Next cycle: HWDATA_O=HWDATA_M0.
- M0 and M1 both NONSEQ in the same cycle, RR_MODE=1, after reset -> M0 granted first, then M1. Repeat both -> grants alternate M0, M1, M0, M1. With RR_MODE=0, M0 always wins.
- M1 INCR4 burst (NONSEQ then 3 SEQ) while M0 requests from the 2nd beat -> M1 holds all 4 beats. ACTIVE_M0=0 until the beat after the last SEQ, then M0 granted.
- Slave stalls (HREADYOUT_S=0 for 3 cycles) during the M0 address phase while M1 starts requesting -> HADDR_O/ACTIVE stay M0 for all stall cycles. Switch to M1 only after the ready cycle.
- M0 locked sequence (HMASTLOCK_M0=1) with IDLE gaps while M1 requests -> M1 blocked until HMASTLOCK_M0=0.
- Assert HRESETn=0 mid-burst of M1 -> HSEL_O=0, HTRANS_O=0, ACTIVE_M0/M1=0 asynchronously. After release, first contention goes to M0.

Source files
------------

// File: rtl/ahblite_busmatrix_outputstage_dtcm.sv
// -----------------------------------------------------------------------------
// ahblite_busmatrix_outputstage_dtcm
//
// Purpose:
//   Output stage of the AHB-lite bus matrix in front of the DTCM slave. It
//   arbitrates between two input stages, M0 (CPU) and M1 (accelerator), and
//   routes the winner's address phase to the single DTCM slave port. Write
//   data follows the master that owns the current data phase.
//
//   Arbitration is combinational (zero-cycle). A master keeps the port for the
//   rest of a burst (SEQ/BUSY) or while it holds HMASTLOCK. While the slave is
//   stalling, the address-phase owner is frozen.
//
// Parameters:
//   RR_MODE    1 = round-robin between M0 and M1 on contention,
//              0 = fixed priority with M0 winning.
//
// Ports:
//   HCLK, HRESETn           clock, asynchronous active-low reset
//   HSEL_Mx .. HWDATA_Mx    AHB-lite address/control/write data from master x
//   HREADYOUT_S             ready from the DTCM slave
//   ACTIVE_M0/ACTIVE_M1     master x owns the current address phase
//   HSEL_O .. HMASTLOCK_O   muxed address/control towards the slave
//   HWDATA_O                write data of the data-phase owner
//   HREADY_O                HREADY towards the slave (= HREADYOUT_S)
// -----------------------------------------------------------------------------
module ahblite_busmatrix_outputstage_dtcm #(
  parameter bit RR_MODE = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL_M0,
  input  logic        HSEL_M1,
  input  logic [31:0] HADDR_M0,
  input  logic [31:0] HADDR_M1,
  input  logic [1:0]  HTRANS_M0,
  input  logic [1:0]  HTRANS_M1,
  input  logic        HWRITE_M0,
  input  logic        HWRITE_M1,
  input  logic [2:0]  HSIZE_M0,
  input  logic [2:0]  HSIZE_M1,
  input  logic [2:0]  HBURST_M0,
  input  logic [2:0]  HBURST_M1,
  input  logic [3:0]  HPROT_M0,
  input  logic [3:0]  HPROT_M1,
  input  logic        HMASTLOCK_M0,
  input  logic        HMASTLOCK_M1,
  input  logic [31:0] HWDATA_M0,
  input  logic [31:0] HWDATA_M1,
  input  logic        HREADYOUT_S,
  output logic        ACTIVE_M0,
  output logic        ACTIVE_M1,
  output logic        HSEL_O,
  output logic [31:0] HADDR_O,
  output logic [1:0]  HTRANS_O,
  output logic        HWRITE_O,
  output logic [2:0]  HSIZE_O,
  output logic [2:0]  HBURST_O,
  output logic [3:0]  HPROT_O,
  output logic        HMASTLOCK_O,
  output logic [31:0] HWDATA_O,
  output logic        HREADY_O
);

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_M0   = 2'd1,
    SEL_M1   = 2'd2
  } sel_e;

  localparam logic [1:0] TRANS_IDLE = 2'b00;
  localparam logic [1:0] TRANS_BUSY = 2'b01;
  localparam logic [1:0] TRANS_SEQ  = 2'b11;

  sel_e r_addr_sel_q;
  sel_e r_data_sel;
  sel_e r_last_grant;
  logic r_hold_q;

  sel_e w_arb;
  sel_e w_addr_sel;
  logic w_hready;
  logic w_req_m0;
  logic w_req_m1;
  logic w_stick_m0;
  logic w_stick_m1;

  assign w_hready = HREADYOUT_S;
  assign HREADY_O = w_hready;

  // NONSEQ or SEQ (HTRANS[1]) is a real request.
  assign w_req_m0 = HSEL_M0 & HTRANS_M0[1];
  assign w_req_m1 = HSEL_M1 & HTRANS_M1[1];

  // Continuation of a burst (SEQ/BUSY) or a locked sequence keeps the port.
  assign w_stick_m0 = HSEL_M0 & ((HTRANS_M0 == TRANS_SEQ) | (HTRANS_M0 == TRANS_BUSY) | HMASTLOCK_M0);
  assign w_stick_m1 = HSEL_M1 & ((HTRANS_M1 == TRANS_SEQ) | (HTRANS_M1 == TRANS_BUSY) | HMASTLOCK_M1);

  always_comb begin
    w_arb = SEL_NONE;
    if (r_addr_sel_q == SEL_M0 && w_stick_m0) begin
      w_arb = SEL_M0;
    end else if (r_addr_sel_q == SEL_M1 && w_stick_m1) begin
      w_arb = SEL_M1;
    end else if (w_req_m0 && w_req_m1) begin
      if (RR_MODE && r_last_grant == SEL_M0) begin
        w_arb = SEL_M1;
      end else begin
        w_arb = SEL_M0;
      end
    end else if (w_req_m0) begin
      w_arb = SEL_M0;
    end else if (w_req_m1) begin
      w_arb = SEL_M1;
    end
  end

  // The address phase is frozen for as long as the slave stalls. Reset forces
  // the bus idle combinationally so nothing leaks out while HRESETn is low.
  always_comb begin
    w_addr_sel = w_arb;
    if (!HRESETn) begin
      w_addr_sel = SEL_NONE;
    end else if (r_hold_q) begin
      w_addr_sel = r_addr_sel_q;
    end
  end

  assign ACTIVE_M0 = (w_addr_sel == SEL_M0);
  assign ACTIVE_M1 = (w_addr_sel == SEL_M1);

  always_comb begin
    HSEL_O      = 1'b0;
    HADDR_O     = 32'd0;
    HTRANS_O    = TRANS_IDLE;
    HWRITE_O    = 1'b0;
    HSIZE_O     = 3'd0;
    HBURST_O    = 3'd0;
    HPROT_O     = 4'd0;
    HMASTLOCK_O = 1'b0;
    case (w_addr_sel)
      SEL_M0: begin
        HSEL_O      = HSEL_M0;
        HADDR_O     = HADDR_M0;
        HTRANS_O    = HTRANS_M0;
        HWRITE_O    = HWRITE_M0;
        HSIZE_O     = HSIZE_M0;
        HBURST_O    = HBURST_M0;
        HPROT_O     = HPROT_M0;
        HMASTLOCK_O = HMASTLOCK_M0;
      end
      SEL_M1: begin
        HSEL_O      = HSEL_M1;
        HADDR_O     = HADDR_M1;
        HTRANS_O    = HTRANS_M1;
        HWRITE_O    = HWRITE_M1;
        HSIZE_O     = HSIZE_M1;
        HBURST_O    = HBURST_M1;
        HPROT_O     = HPROT_M1;
        HMASTLOCK_O = HMASTLOCK_M1;
      end
      default: ;
    endcase
  end

  always_comb begin
    HWDATA_O = 32'd0;
    case (r_data_sel)
      SEL_M0:  HWDATA_O = HWDATA_M0;
      SEL_M1:  HWDATA_O = HWDATA_M1;
      default: HWDATA_O = 32'd0;
    endcase
  end

  // last_grant starts at M1 so M0 wins the first contention after reset.
  // BUSY/IDLE phases are forwarded but never open a data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr_sel_q <= SEL_NONE;
      r_data_sel   <= SEL_NONE;
      r_last_grant <= SEL_M1;
      r_hold_q     <= 1'b0;
    end else begin
      r_hold_q     <= ~w_hready;
      r_addr_sel_q <= w_addr_sel;
      if (w_hready) begin
        if (w_addr_sel != SEL_NONE && HTRANS_O[1]) begin
          r_data_sel   <= w_addr_sel;
          r_last_grant <= w_addr_sel;
        end else begin
          r_data_sel <= SEL_NONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahblite_busmatrix_outputstage_dtcm.sv
// -----------------------------------------------------------------------------
// tb_ahblite_busmatrix_outputstage_dtcm
//
// Purpose:
//   Self-checking bench for the DTCM output-stage arbiter. Two instances share
//   the same stimulus: u_rr (round-robin) and u_fp (fixed priority). A
//   transaction-level model tracks address owner, stall, last grant and data
//   owner per instance and predicts every output each cycle; directed steps add
//   explicit expectations for the key scenarios, followed by random traffic.
// -----------------------------------------------------------------------------
module tb_ahblite_busmatrix_outputstage_dtcm;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  // Master-side stimulus, index 0 = M0, 1 = M1.
  logic [1:0]  hsel;
  logic [1:0]  hwrite;
  logic [1:0]  lock;
  logic [31:0] haddr  [2];
  logic [31:0] hwdata [2];
  logic [1:0]  htrans [2];
  logic [2:0]  hsize  [2];
  logic [2:0]  hburst [2];
  logic [3:0]  hprot  [2];
  logic        hready_s;

  // Outputs, index 0 = u_rr, 1 = u_fp.
  logic [1:0]  act0, act1, hsel_o, hwrite_o, lock_o, hready_o;
  logic [31:0] haddr_o  [2];
  logic [31:0] hwdata_o [2];
  logic [1:0]  htrans_o [2];
  logic [2:0]  hsize_o  [2];
  logic [2:0]  hburst_o [2];
  logic [3:0]  hprot_o  [2];

  ahblite_busmatrix_outputstage_dtcm #(.RR_MODE(1'b1)) u_rr (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HSEL_M0(hsel[0]), .HSEL_M1(hsel[1]),
    .HADDR_M0(haddr[0]), .HADDR_M1(haddr[1]),
    .HTRANS_M0(htrans[0]), .HTRANS_M1(htrans[1]),
    .HWRITE_M0(hwrite[0]), .HWRITE_M1(hwrite[1]),
    .HSIZE_M0(hsize[0]), .HSIZE_M1(hsize[1]),
    .HBURST_M0(hburst[0]), .HBURST_M1(hburst[1]),
    .HPROT_M0(hprot[0]), .HPROT_M1(hprot[1]),
    .HMASTLOCK_M0(lock[0]), .HMASTLOCK_M1(lock[1]),
    .HWDATA_M0(hwdata[0]), .HWDATA_M1(hwdata[1]),
    .HREADYOUT_S(hready_s),
    .ACTIVE_M0(act0[0]), .ACTIVE_M1(act1[0]),
    .HSEL_O(hsel_o[0]), .HADDR_O(haddr_o[0]), .HTRANS_O(htrans_o[0]),
    .HWRITE_O(hwrite_o[0]), .HSIZE_O(hsize_o[0]), .HBURST_O(hburst_o[0]),
    .HPROT_O(hprot_o[0]), .HMASTLOCK_O(lock_o[0]), .HWDATA_O(hwdata_o[0]),
    .HREADY_O(hready_o[0])
  );

  ahblite_busmatrix_outputstage_dtcm #(.RR_MODE(1'b0)) u_fp (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HSEL_M0(hsel[0]), .HSEL_M1(hsel[1]),
    .HADDR_M0(haddr[0]), .HADDR_M1(haddr[1]),
    .HTRANS_M0(htrans[0]), .HTRANS_M1(htrans[1]),
    .HWRITE_M0(hwrite[0]), .HWRITE_M1(hwrite[1]),
    .HSIZE_M0(hsize[0]), .HSIZE_M1(hsize[1]),
    .HBURST_M0(hburst[0]), .HBURST_M1(hburst[1]),
    .HPROT_M0(hprot[0]), .HPROT_M1(hprot[1]),
    .HMASTLOCK_M0(lock[0]), .HMASTLOCK_M1(lock[1]),
    .HWDATA_M0(hwdata[0]), .HWDATA_M1(hwdata[1]),
    .HREADYOUT_S(hready_s),
    .ACTIVE_M0(act0[1]), .ACTIVE_M1(act1[1]),
    .HSEL_O(hsel_o[1]), .HADDR_O(haddr_o[1]), .HTRANS_O(htrans_o[1]),
    .HWRITE_O(hwrite_o[1]), .HSIZE_O(hsize_o[1]), .HBURST_O(hburst_o[1]),
    .HPROT_O(hprot_o[1]), .HMASTLOCK_O(lock_o[1]), .HWDATA_O(hwdata_o[1]),
    .HREADY_O(hready_o[1])
  );

  int checks = 0;
  int errors = 0;

  // Model state per instance; owners are -1 (none), 0 (M0) or 1 (M1).
  int m_prev [2];
  int m_last [2];
  int m_dsel [2];
  int m_cur  [2];
  bit m_stall[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_prev[k]  = -1;
      m_last[k]  = 1;
      m_dsel[k]  = -1;
      m_cur[k]   = -1;
      m_stall[k] = 1'b0;
    end
  endtask

  // Who owns the address phase given the current inputs and history.
  function automatic int exp_owner(input int k);
    int  p;
    bit  r0, r1;
    if (!HRESETn) return -1;
    if (m_stall[k]) return m_prev[k];
    p = m_prev[k];
    if (p >= 0 && hsel[p] && (htrans[p] == 2'b11 || htrans[p] == 2'b01 || lock[p])) return p;
    r0 = hsel[0] && htrans[0][1];
    r1 = hsel[1] && htrans[1][1];
    if (r0 && r1) return (k == 0) ? 1 - m_last[k] : 0;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  function automatic logic [46:0] exp_bus(input int o);
    if (o < 0) return '0;
    return {hsel[o], haddr[o], htrans[o], hwrite[o], hsize[o], hburst[o], hprot[o], lock[o]};
  endfunction

  function automatic logic [46:0] obs_bus(input int k);
    return {hsel_o[k], haddr_o[k], htrans_o[k], hwrite_o[k], hsize_o[k], hburst_o[k],
            hprot_o[k], lock_o[k]};
  endfunction

  task automatic sample();
    @(negedge HCLK);
    for (int k = 0; k < 2; k++) begin
      logic [31:0] wd;
      int          o;
      o = exp_owner(k);
      m_cur[k] = o;
      wd = 32'd0;
      if (m_dsel[k] >= 0) wd = hwdata[m_dsel[k]];
      chk($sformatf("model_active_i%0d", k), {62'd0, act1[k], act0[k]},
          {62'd0, (o == 1), (o == 0)});
      chk($sformatf("model_bus_i%0d", k), {17'd0, obs_bus(k)}, {17'd0, exp_bus(o)});
      chk($sformatf("model_hwdata_i%0d", k), {32'd0, hwdata_o[k]}, {32'd0, wd});
      chk($sformatf("model_hready_i%0d", k), {63'd0, hready_o[k]}, {63'd0, hready_s});
    end
  endtask

  task automatic adv();
    @(posedge HCLK);
    if (!HRESETn) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_stall[k] = !hready_s;
        if (hready_s) begin
          if (m_cur[k] >= 0 && htrans[m_cur[k]][1]) begin
            m_dsel[k] = m_cur[k];
            m_last[k] = m_cur[k];
          end else begin
            m_dsel[k] = -1;
          end
        end
        m_prev[k] = m_cur[k];
      end
    end
    #1;
  endtask

  task automatic cycle();
    sample();
    adv();
  endtask

  task automatic idle_all();
    hsel = 2'b00; lock = 2'b00;
    htrans[0] = 2'b00; htrans[1] = 2'b00;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    model_reset();
    cycle();
    HRESETn = 1'b1;
  endtask

  initial begin
    HRESETn = 1'b0;
    hready_s = 1'b1;
    hwrite = 2'b00;
    for (int i = 0; i < 2; i++) begin
      haddr[i] = 32'd0; hwdata[i] = 32'd0; hsize[i] = 3'd0;
      hburst[i] = 3'd0; hprot[i] = 4'd0;
    end
    idle_all();
    model_reset();
    cycle();
    // Reset state, even with a request pending on the inputs.
    hsel[1] = 1'b1; htrans[1] = 2'b10;
    sample();
    chk("reset_hsel", hsel_o[0], 1'b0);
    chk("reset_act1", act1[0], 1'b0);
    adv();
    idle_all();
    HRESETn = 1'b1;

    // Single M0 write: zero-cycle address, data one phase later.
    hsel[0] = 1'b1; htrans[0] = 2'b10; hwrite[0] = 1'b1; hsize[0] = 3'd2;
    haddr[0] = 32'h2000_0010; hwdata[0] = 32'hA5A5_0001;
    sample();
    chk("single_act0", act0[0], 1'b1);
    chk("single_haddr", haddr_o[0], 32'h2000_0010);
    chk("single_htrans", htrans_o[0], 2'd2);
    adv();
    idle_all();
    sample();
    chk("single_hwdata", hwdata_o[0], 32'hA5A5_0001);
    adv();

    // Contention straight after reset: RR alternates from M0, FP always M0.
    do_reset();
    hsel = 2'b11; htrans[0] = 2'b10; htrans[1] = 2'b10;
    haddr[0] = 32'h2000_0040; haddr[1] = 32'h2000_0080;
    hwdata[0] = 32'h0000_00A0; hwdata[1] = 32'h0000_00B1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk($sformatf("rr_act0_%0d", i), act0[0], (i % 2 == 0));
      chk($sformatf("rr_act1_%0d", i), act1[0], (i % 2 == 1));
      chk($sformatf("fp_act0_%0d", i), act0[1], 1'b1);
      adv();
    end
    idle_all();
    cycle();

    // M1 INCR4 burst; M0 requests from beat 2 and must wait for the burst end.
    hsel[1] = 1'b1; htrans[1] = 2'b10; hburst[1] = 3'd3; haddr[1] = 32'h2000_0100;
    sample();
    chk("burst_first_act1", act1[0], 1'b1);
    adv();
    for (int b = 1; b < 4; b++) begin
      haddr[1] = haddr[1] + 32'd4; htrans[1] = 2'b11;
      hsel[0] = 1'b1; htrans[0] = 2'b10; haddr[0] = 32'h2000_0300;
      sample();
      chk($sformatf("burst_rr_act0_b%0d", b), act0[0], 1'b0);
      chk($sformatf("burst_fp_act0_b%0d", b), act0[1], 1'b0);
      adv();
    end
    hsel[1] = 1'b0; htrans[1] = 2'b00;
    sample();
    chk("burst_end_rr_act0", act0[0], 1'b1);
    chk("burst_end_fp_act0", act0[1], 1'b1);
    adv();
    idle_all();
    cycle();

    // Slave stall during an M0 address phase while M1 starts requesting.
    hsel[0] = 1'b1; htrans[0] = 2'b10; haddr[0] = 32'h2000_0200; hready_s = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (s >= 1) begin
        hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h2000_0204;
      end
      sample();
      chk($sformatf("stall_act0_%0d", s), act0[0], 1'b1);
      chk($sformatf("stall_haddr_%0d", s), haddr_o[0], 32'h2000_0200);
      adv();
    end
    hready_s = 1'b1;
    sample();
    chk("stall_ready_act0", act0[0], 1'b1);
    adv();
    hsel[0] = 1'b0; htrans[0] = 2'b00;
    sample();
    chk("stall_switch_act1", act1[0], 1'b1);
    chk("stall_switch_haddr", haddr_o[0], 32'h2000_0204);
    adv();
    idle_all();
    cycle();

    // Locked M0 sequence with IDLE gaps blocks M1 until the lock drops.
    for (int c = 0; c < 4; c++) begin
      hsel[0] = 1'b1; lock[0] = 1'b1; htrans[0] = (c % 2 == 0) ? 2'b10 : 2'b00;
      if (c >= 1) begin
        hsel[1] = 1'b1; htrans[1] = 2'b10;
      end
      sample();
      chk($sformatf("lock_rr_act1_%0d", c), act1[0], 1'b0);
      chk($sformatf("lock_fp_act0_%0d", c), act0[1], 1'b1);
      adv();
    end
    lock[0] = 1'b0; hsel[0] = 1'b0; htrans[0] = 2'b00;
    sample();
    chk("unlock_rr_act1", act1[0], 1'b1);
    chk("unlock_fp_act1", act1[1], 1'b1);
    adv();
    idle_all();
    cycle();

    // Asynchronous reset in the middle of an M1 burst.
    hsel[1] = 1'b1; htrans[1] = 2'b10; hburst[1] = 3'd3;
    cycle();
    htrans[1] = 2'b11;
    cycle();
    HRESETn = 1'b0;
    model_reset();
    #1;
    chk("midrst_hsel", hsel_o[0], 1'b0);
    chk("midrst_htrans", htrans_o[0], 2'd0);
    chk("midrst_act0", act0[0], 1'b0);
    chk("midrst_act1", act1[0], 1'b0);
    cycle();
    HRESETn = 1'b1;
    hsel = 2'b11; htrans[0] = 2'b10; htrans[1] = 2'b10;
    sample();
    chk("postrst_rr_act0", act0[0], 1'b1);
    adv();
    idle_all();
    cycle();

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      hsel     = 2'($urandom);
      hwrite   = 2'($urandom);
      lock[0]  = ($urandom_range(0, 7) == 0);
      lock[1]  = ($urandom_range(0, 7) == 0);
      hready_s = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 2; i++) begin
        htrans[i] = 2'($urandom_range(0, 3));
        haddr[i]  = $urandom;
        hwdata[i] = $urandom;
        hsize[i]  = 3'($urandom);
        hburst[i] = 3'($urandom);
        hprot[i]  = 4'($urandom);
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
